// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Brief    : Shared constants for the CPU memory-side blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          c_STATE_W         = 2;
    localparam logic [1:0]  c_ST_IDLE         = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE        = 2'd1;
    localparam logic [1:0]  c_ST_WAIT         = 2'd2;
    localparam logic [1:0]  c_ST_RESP         = 2'd3;

    // kseg0/kseg1 fold onto the low 512 MB of physical space
    localparam logic [31:0] c_KSEG_MASK       = 32'h1fff_ffff;
    localparam logic [31:0] c_WORD_MASK       = 32'hffff_fffc;
    localparam int          c_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/sram_addr_xlate.sv
`default_nettype none
// ============================================================================
// Module   : sram_addr_xlate
// Brief    : Combinational virtual-to-physical map for kseg0/kseg1.
// Revision : 1.0 - initial release
// ============================================================================
module sram_addr_xlate
    import cpu_pkg::*;
#(
    parameter int ADDR_MAP = 1
) (
    input  logic [31:0] i_vaddr,
    output logic [31:0] o_paddr
);

    generate
        if (ADDR_MAP != 0) begin : g_map
            assign o_paddr = (i_vaddr[31:30] == 2'b10) ? (i_vaddr & c_KSEG_MASK) : i_vaddr;
        end else begin : g_pass
            assign o_paddr = i_vaddr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Merges inst/data SRAM request ports onto one memory bus,
//            data first, one transaction outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_MAP = 1,
    parameter int TIMEOUT  = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic [31:0] perf_fetch_stall
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_owner_inst;
    logic                 r_mem_req;
    logic                 r_wr;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_inst_rdata;
    logic [31:0]          r_data_rdata;
    logic [31:0]          r_perf;
    logic [7:0]           r_cnt;
    logic                 r_inst_data_ok;
    logic                 r_data_data_ok;

    logic                 w_idle;
    logic [31:0]          w_req_addr;
    logic [31:0]          w_phys;
    logic [31:0]          w_resp_data;

    assign w_idle       = (r_state == c_ST_IDLE);
    assign data_addr_ok = w_idle & data_req;
    assign inst_addr_ok = w_idle & inst_req & ~data_req;
    assign w_req_addr   = data_req ? data_addr : inst_addr;
    // A timed-out read returns zero
    assign w_resp_data  = mem_rvalid ? mem_rdata : 32'h0000_0000;

    sram_addr_xlate #(
        .ADDR_MAP (ADDR_MAP)
    ) u_xlate (
        .i_vaddr  (w_req_addr),
        .o_paddr  (w_phys)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= c_ST_IDLE;
            r_owner_inst   <= 1'b0;
            r_mem_req      <= 1'b0;
            r_wr           <= 1'b0;
            r_wstrb        <= 4'b0000;
            r_addr         <= 32'h0;
            r_wdata        <= 32'h0;
            r_inst_rdata   <= 32'h0;
            r_data_rdata   <= 32'h0;
            r_perf         <= 32'h0;
            r_cnt          <= 8'h0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
        end else begin
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (data_req || inst_req) begin
                        r_owner_inst <= ~data_req;
                        r_wr         <= data_req & data_wr;
                        r_wstrb      <= (data_req && data_wr) ? data_wstrb : 4'b0000;
                        r_addr       <= w_phys & c_WORD_MASK;
                        r_wdata      <= data_wdata;
                        r_mem_req    <= 1'b1;
                        r_state      <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= 8'h0;
                        if (r_wr) begin
                            r_data_data_ok <= 1'b1;
                            r_state        <= c_ST_RESP;
                        end else begin
                            r_state        <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (mem_rvalid || (r_cnt == c_TIMEOUT_LAST)) begin
                        if (r_owner_inst) begin
                            r_inst_rdata <= w_resp_data;
                        end else begin
                            r_data_rdata <= w_resp_data;
                        end
                        r_inst_data_ok <= r_owner_inst;
                        r_data_data_ok <= ~r_owner_inst;
                        r_state        <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
            if (inst_req && !inst_addr_ok) begin
                r_perf <= r_perf + 32'd1;
            end
        end
    end

    assign inst_data_ok     = r_inst_data_ok;
    assign inst_rdata       = r_inst_rdata;
    assign data_data_ok     = r_data_data_ok;
    assign data_rdata       = r_data_rdata;
    assign mem_req          = r_mem_req;
    assign mem_wr           = r_wr;
    assign mem_wstrb        = r_wstrb;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign perf_fetch_stall = r_perf;

endmodule
`default_nettype wire
